// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix engine's multiplier lanes.
// Holds the stream-driver state encoding and float bit patterns.
package matmul_pkg;

  localparam int FP_W = 32;

  localparam logic [FP_W-1:0] FP_QNAN = 32'hFFC00000;
  localparam logic [FP_W-1:0] FP_PINF = 32'h7F800000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_RD_A,
    S_WAIT_A,
    S_SEND_A,
    S_RD_B,
    S_WAIT_B,
    S_SEND_B,
    S_GET_Z,
    S_WRITE_Z,
    S_DONE
  } drv_state_t;

endpackage

// File: rtl/hs_source.sv
// Single stb/data holding register for one outgoing operand channel.
// Data and stb stay put until the stb&ack edge, then stb drops.
module hs_source
  import matmul_pkg::*;
#(
  parameter int W = FP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ack,
  output logic         stb,
  output logic [W-1:0] data,
  output logic         xfer
);

  assign xfer = stb & ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      stb  <= 1'b0;
      data <= '0;
    end else if (load) begin
      stb  <= 1'b1;
      data <= din;
    end else if (xfer) begin
      stb  <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_stream_driver.sv
// Walks count operand pairs through one multiplier lane, one pair
// in flight, writing each product back to memory in order.
module mul_stream_driver
  import matmul_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_z,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [FP_W-1:0]   rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [FP_W-1:0]   wr_data,
  output logic [FP_W-1:0]   mul_a,
  output logic [FP_W-1:0]   mul_b,
  output logic              mul_a_stb,
  output logic              mul_b_stb,
  input  logic              mul_a_ack,
  input  logic              mul_b_ack,
  input  logic [FP_W-1:0]   mul_z,
  input  logic              mul_z_stb,
  output logic              mul_z_ack
);

  drv_state_t state_q, state_d;

  logic [ADDR_W-1:0] ba_q, bb_q, bz_q;
  logic [CNT_W-1:0]  cnt_q, idx_q, idx_inc;
  logic [ADDR_W-1:0] off;
  logic [FP_W-1:0]   z_q;
  logic              a_xfer, b_xfer;

  assign idx_inc = idx_q + CNT_W'(1);
  assign off     = idx_q[ADDR_W-1:0];

  hs_source #(.W(FP_W)) u_src_a (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == S_WAIT_A),
    .din  (rd_data),
    .ack  (mul_a_ack),
    .stb  (mul_a_stb),
    .data (mul_a),
    .xfer (a_xfer)
  );

  hs_source #(.W(FP_W)) u_src_b (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == S_WAIT_B),
    .din  (rd_data),
    .ack  (mul_b_ack),
    .stb  (mul_b_stb),
    .data (mul_b),
    .xfer (b_xfer)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ba_q    <= '0;
      bb_q    <= '0;
      bz_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      // Latch on the accept edge so LOAD can already branch on count.
      if (state_q == S_IDLE && start) begin
        ba_q  <= base_a;
        bb_q  <= base_b;
        bz_q  <= base_z;
        cnt_q <= count;
        idx_q <= '0;
      end
      if (state_q == S_GET_Z && mul_z_stb) z_q <= mul_z;
      if (state_q == S_WRITE_Z) idx_q <= idx_inc;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    mul_z_ack = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        state_d = (cnt_q == '0) ? S_DONE : S_RD_A;
      end
      S_RD_A: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = ba_q + off;
        state_d = S_WAIT_A;
      end
      S_WAIT_A: begin
        busy    = 1'b1;
        state_d = S_SEND_A;
      end
      S_SEND_A: begin
        busy = 1'b1;
        if (a_xfer) state_d = S_RD_B;
      end
      S_RD_B: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = bb_q + off;
        state_d = S_WAIT_B;
      end
      S_WAIT_B: begin
        busy    = 1'b1;
        state_d = S_SEND_B;
      end
      S_SEND_B: begin
        busy = 1'b1;
        if (b_xfer) state_d = S_GET_Z;
      end
      S_GET_Z: begin
        busy      = 1'b1;
        mul_z_ack = 1'b1;
        if (mul_z_stb) state_d = S_WRITE_Z;
      end
      S_WRITE_Z: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = bz_q + off;
        wr_data = z_q;
        state_d = (idx_inc == cnt_q) ? S_DONE : S_RD_A;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul_stream_driver.sv
// Bench for mul_stream_driver: memory, multiplier responder with
// programmable delays, and a queue-based job model.
module tb_mul_stream_driver;
  import matmul_pkg::*;

  localparam int AW = 8;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_a = '0, base_b = '0, base_z = '0;
  logic [CW-1:0] count = '0;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [31:0]   rd_data, wr_data, mul_a, mul_b, mul_z;
  logic          mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack;
  logic          mul_z_stb, mul_z_ack;

  mul_stream_driver #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_a(base_a), .base_b(base_b), .base_z(base_z),
    .count(count), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
    .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s", name);
  endtask

  // Stand-in multiplier: known float pairs, otherwise a bit mix.
  function automatic logic [31:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    case ({a, b})
      64'h40000000_40400000: return 32'h40C00000;
      64'h3FC00000_C0800000: return 32'hC0C00000;
      64'h00000000_40A00000: return 32'h00000000;
      {FP_PINF, 32'h0}:      return FP_QNAN;
      default: return a ^ {b[15:0], b[31:16]} ^ 32'h9E3779B9;
    endcase
  endfunction

  // Memory with 1-cycle read latency plus a bench preload port.
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    shadow[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Multiplier responder: get_a, get_b, compute, put_z.
  int max_dly = 0;
  int ph = 0;
  int dly = 0;
  logic [31:0] ra, rb;

  function automatic int rnd();
    return (max_dly == 0) ? 0 : int'($urandom_range(max_dly, 0));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ph <= 0;
      dly <= 0;
      mul_a_ack <= 1'b0;
      mul_b_ack <= 1'b0;
      mul_z_stb <= 1'b0;
      mul_z <= '0;
    end else begin
      case (ph)
        0: if (mul_a_ack && mul_a_stb) begin
             ra <= mul_a; mul_a_ack <= 1'b0; ph <= 1; dly <= rnd();
           end else if (!mul_a_ack) begin
             if (dly == 0) mul_a_ack <= 1'b1; else dly <= dly - 1;
           end
        1: if (mul_b_ack && mul_b_stb) begin
             rb <= mul_b; mul_b_ack <= 1'b0; ph <= 2; dly <= rnd();
           end else if (!mul_b_ack) begin
             if (dly == 0) mul_b_ack <= 1'b1; else dly <= dly - 1;
           end
        2: if (dly == 0) begin
             mul_z <= fmul(ra, rb); mul_z_stb <= 1'b1; ph <= 3;
           end else dly <= dly - 1;
        default: if (mul_z_stb && mul_z_ack) begin
             mul_z_stb <= 1'b0; ph <= 0; dly <= rnd();
           end
      endcase
    end
  end

  // Expected traffic queues and per-job observation counters.
  typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
  wr_t        wq[$];
  logic [7:0] rq[$];
  int wr_cnt, rd_cnt, done_cnt, stb_cnt;

  logic pa_stb = 0, pa_ack = 0, pb_stb = 0, pb_ack = 0;
  logic pz_ack = 0, pz_stb = 0, prst = 1;
  logic [31:0] pa = 0, pb = 0;

  always @(negedge clk) begin
    if (!rst && !prst) begin
      if (wr_en) begin
        wr_cnt++;
        if (wq.size() == 0) fail_now("wr_unexpected");
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", {24'b0, wr_addr}, {24'b0, e.addr});
          chk("wr_data", wr_data, e.data);
        end
      end
      if (rd_en) begin
        rd_cnt++;
        if (rq.size() == 0) fail_now("rd_unexpected");
        else chk("rd_addr", {24'b0, rd_addr}, {24'b0, rq.pop_front()});
      end
      if (done) done_cnt++;
      if (mul_a_stb || mul_b_stb) stb_cnt++;
      chk("busy_done_excl", {31'b0, busy && done}, 0);
      if (pa_stb && !pa_ack) begin
        chk("a_stb_hold", {31'b0, mul_a_stb}, 1);
        chk("a_data_hold", mul_a, pa);
      end
      if (pb_stb && !pb_ack) begin
        chk("b_stb_hold", {31'b0, mul_b_stb}, 1);
        chk("b_data_hold", mul_b, pb);
      end
      if (pz_ack && !pz_stb) chk("z_ack_hold", {31'b0, mul_z_ack}, 1);
    end
    pa_stb = mul_a_stb; pa_ack = mul_a_ack; pa = mul_a;
    pb_stb = mul_b_stb; pb_ack = mul_b_ack; pb = mul_b;
    pz_ack = mul_z_ack; pz_stb = mul_z_stb; prst = rst;
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"},
        {25'b0, busy, done, rd_en, wr_en, mul_a_stb, mul_b_stb, mul_z_ack}, 0);
    chk({tag, "_rd_addr"}, {24'b0, rd_addr}, 0);
    chk({tag, "_wr_addr"}, {24'b0, wr_addr}, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
  endtask

  // Runs one job; exp_lat 0 skips the latency check, abort_at>0
  // asserts rst at that cycle after the start edge.
  task automatic run_job(input logic [7:0] ba, input logic [7:0] bb,
                         input logic [7:0] bz, input int n,
                         input int exp_lat, input int abort_at,
                         input int ncommit);
    int cyc;
    int limit;
    limit = 2 + n * 60 + 20;
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; stb_cnt = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] aa, ab, az;
      logic [31:0] z;
      aa = ba + 8'(i);
      ab = bb + 8'(i);
      az = bz + 8'(i);
      rq.push_back(aa);
      rq.push_back(ab);
      if (i < ncommit) begin
        z = fmul(shadow[aa], shadow[ab]);
        wq.push_back('{addr: az, data: z});
        shadow[az] = z;
      end
    end
    base_a = ba; base_b = bb; base_z = bz; count = CW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("busy_cycle1", {31'b0, busy}, 1);
    while (cyc < limit) begin
      if (abort_at == cyc || done) break;
      @(negedge clk);
      cyc++;
    end
    if (abort_at > 0) begin
      chk("in_send_b", {31'b0, mul_b_stb}, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_outputs_zero("after_rst");
      rst = 1'b0;
      chk("abort_wq_drained", wq.size(), 0);
      rq.delete();
      wq.delete();
      repeat (3) @(negedge clk);
      chk("abort_wr_count", wr_cnt, ncommit);
    end else begin
      if (!done) fail_now("done_timeout");
      else if (exp_lat > 0) chk("latency", cyc, exp_lat);
      @(negedge clk);
      chk("done_pulses", done_cnt, 1);
      chk("done_low_after", {31'b0, done}, 0);
      chk("busy_low_after", {31'b0, busy}, 0);
      chk("wr_count", wr_cnt, n);
      chk("rd_count", rd_cnt, 2 * n);
      chk("wq_drained", wq.size(), 0);
      if (n == 0) chk("no_stb", stb_cnt, 0);
    end
    for (int i = 0; i < n; i++) begin
      logic [7:0] az;
      az = bz + 8'(i);
      chk("mem_z", mem[az], shadow[az]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 2.0 * 3.0
    poke(8'h10, 32'h40000000);
    poke(8'h20, 32'h40400000);
    run_job(8'h10, 8'h20, 8'h30, 1, 11, 0, 1);
    chk("lit_2x3", mem[8'h30], 32'h40C00000);

    // (1.5,-4) (0,5) (inf,0)
    poke(8'h40, 32'h3FC00000); poke(8'h50, 32'hC0800000);
    poke(8'h41, 32'h00000000); poke(8'h51, 32'h40A00000);
    poke(8'h42, FP_PINF);      poke(8'h52, 32'h00000000);
    run_job(8'h40, 8'h50, 8'h60, 3, 29, 0, 3);
    chk("lit_m6", mem[8'h60], 32'hC0C00000);
    chk("lit_zero", mem[8'h61], 32'h00000000);
    chk("lit_qnan", mem[8'h62], 32'hFFC00000);

    run_job(8'h70, 8'h71, 8'h72, 0, 2, 0, 0);

    // Address wrap; element writes feed later A reads.
    run_job(8'hFE, 8'h10, 8'hFF, 4, 38, 0, 4);

    max_dly = 7;
    run_job(8'h80, 8'h90, 8'hA0, 6, 0, 0, 6);
    run_job(8'h88, 8'h98, 8'hA8, 5, 0, 0, 5);
    run_job(8'hC0, 8'hC8, 8'hE0, 0, 0, 0, 0);
    max_dly = 0;
    repeat (10) @(negedge clk);

    // Reset during SEND_B of element 2, then a clean rerun.
    run_job(8'hB0, 8'hB8, 8'hD0, 3, 0, 16, 1);
    run_job(8'hB0, 8'hB8, 8'hD8, 3, 29, 0, 3);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
